pbus_cycle_ctrl: RTL and testbench
==================================

# pbus_cycle_ctrl

Sequencer between the asynchronous processor bus (PBus) and the synchronous core datapath. It synchronises the active-low PBus read and write strobes into the `Clk` domain and latches the address and write data. It issues single-cycle RD/WR commands to the core, waits for the core's acknowledge with a bounded timeout, and drives `PBusReadyN` and the data-output-buffer enable. It replaces free-running strobe decoding with a strict one-transaction-at-a-time handshake.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in each strobe synchroniser; minimum 2.
- `TIMEOUT`, default 255: maximum number of WAITACK cycles; minimum 1. The counter width is ceil(log2(TIMEOUT+1)).

Ports:
- `Clk` in 1: single clock; every flop is on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `PBusRDN` in 1: PBus read strobe, active-low, asynchronous to `Clk`.
- `PBusWRN` in 1: PBus write strobe, active-low, asynchronous to `Clk`.
- `PBusAddr` in [16:2]: word address, stable while a strobe is low.
- `PBusDataIn` in 32: write data from the bus pads, stable while `PBusWRN` is low.
- `RdData` in 32: read data from the core, valid when `Ack` is high.
- `Ack` in 1: core completion, sampled only in WAITACK.
- `ErrClr` in 1: synchronous clear of `BusErr`.
- `RD` out 1: one-cycle read command to the core.
- `WR` out 1: one-cycle write command to the core.
- `Addr` out [16:2]: latched address.
- `WrData` out 32: latched write data.
- `PBusDataOut` out 32: registered read data for the output buffers.
- `DataOE` out 1: output-buffer enable for the read data.
- `PBusReadyN` out 1: bus ready, active-low.
- `BusErr` out 1: sticky error flag.

## Operation
- The synchronised strobes `rd_s` and `wr_s` are active-high internally. The FSM sees only the synchronised values.
- Reset values: `RD`=0, `WR`=0, `Addr`=0, `WrData`=0, `PBusDataOut`=0, `DataOE`=0, `PBusReadyN`=1, `BusErr`=0. The FSM resets to IDLE and the synchronisers reset to "strobe inactive".
- Reset mid-transaction aborts it immediately; no command is reissued after reset.
- FSM states: IDLE, CMD, WAITACK, READY, DRAIN.
- **IDLE:**
  - `rd_s` only: latch `Addr`, record op=read, go to CMD.
  - `wr_s` only: latch `Addr` and `WrData`, record op=write, go to CMD.
  - Both set: set `BusErr`, issue no command, go to DRAIN.
- **CMD:** `RD` or `WR` is high for exactly this one cycle. Clear the timeout counter, then go to WAITACK.
- **WAITACK:**
  - `Ack` high: for a read, capture `PBusDataOut`<=`RdData`. Go to READY, or to DRAIN if the strobe has already released.
  - Counter reaches `TIMEOUT`-1 with no `Ack`: set `BusErr`. For a read, `PBusDataOut`<=32'hFFFF_FFFF. Take the same exit as for `Ack`.
  - Otherwise: increment the counter.
  - A strobe released early does not cancel the command; the core still completes it.
- **READY:**
  - `PBusReadyN`=0.
  - `DataOE`=1 for reads and 0 for writes.
  - Stay until the recorded strobe's synchronised value goes inactive, then go to IDLE. `PBusReadyN` returns to 1 and `DataOE` to 0 on that same edge.
- **DRAIN:** outputs stay at idle values. Go to IDLE once both `rd_s` and `wr_s` are inactive. `PBusReadyN` is never asserted for an aborted or conflicting cycle.
- `BusErr`:
  - Sticky; cleared only by `ErrClr` or `Reset`.
  - A set event in the same cycle as `ErrClr` wins (flag ends up 1).
- `Ack` outside WAITACK is ignored.
- The latched `Addr` and `WrData` hold from CMD until the next IDLE-exit.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Strobe entry, edge numbering:
  - A strobe low is first sampled at edge 0.
  - `rd_s`/`wr_s` become visible after edge `SYNC_STAGES`-1.
  - The IDLE->CMD transition happens at edge `SYNC_STAGES`.
  - `RD`/`WR` are high from edge `SYNC_STAGES` to edge `SYNC_STAGES`+1.
- Earliest `Ack` is the cycle after the RD/WR pulse. `Ack` sampled at edge e drives `PBusReadyN` low after edge e.
- Zero-wait core (`Ack` tied high): `PBusReadyN` goes low at edge `SYNC_STAGES`+2 = 4 with the defaults.
- WAITACK lasts at most `TIMEOUT` cycles.
- Strobe release:
  - Release is seen `SYNC_STAGES` edges after the pin rises.
  - `PBusReadyN` rises on the following edge.
- Back-to-back cycles are separated by at least one IDLE cycle.

## Test plan
- **Zero-wait read:** `Ack`=1, `RdData`=32'h1234_5678, `PBusAddr`=15'h0042, `PBusRDN` low. Expect `RD` pulsed 1 cycle, `Addr`=15'h0042, `PBusReadyN` low at edge 4, `DataOE`=1, `PBusDataOut`=32'h1234_5678. After `PBusRDN` rises: `PBusReadyN`=1 and `DataOE`=0 within 3 edges.
- **Waited write:** `PBusWRN` low, `PBusDataIn`=32'hCAFE_0001, `Ack` raised 5 cycles after `WR`. Expect one `WR` pulse, `WrData`=32'hCAFE_0001, `PBusReadyN` low after `Ack`, `DataOE` stays 0.
- **Timeout:** `TIMEOUT`=4, read with `Ack`=0. Expect WAITACK for 4 cycles, `BusErr`=1, `PBusDataOut`=32'hFFFF_FFFF, `PBusReadyN` low. Pulsing `ErrClr` returns `BusErr` to 0.
- **Strobe conflict:** `PBusRDN` and `PBusWRN` low together. Expect no `RD`/`WR` pulse, `BusErr`=1, `PBusReadyN` held 1. The FSM returns to IDLE after both strobes rise.
- **Early release:** `PBusRDN` low for 3 cycles, `Ack` delayed 10 cycles. Expect exactly one `RD` pulse, `PBusReadyN` never low, and a following read served normally.
- **Reset mid-cycle:** assert `Reset` in WAITACK. Expect all outputs at reset values immediately and no further `RD` pulse after deassertion while `PBusRDN` stays high.

Source files
------------

// File: rtl/pbus_cycle_ctrl.sv
// pbus_cycle_ctrl
//   Sequencer between the asynchronous processor bus (PBus) and the synchronous
//   core datapath. Runs one transaction at a time: it synchronises the active-low
//   PBus strobes, latches address/write data, issues a single-cycle RD or WR
//   command, waits (bounded) for the core Ack, then holds PBusReadyN low until
//   the bus releases its strobe.
//
// Parameters
//   SYNC_STAGES : flops per strobe synchroniser (>= 2)
//   TIMEOUT     : maximum WAITACK cycles before an error completion (>= 1)
//
// Ports
//   Clk, Reset            : clock (rising edge), asynchronous active-high reset
//   PBusRDN, PBusWRN      : asynchronous active-low read/write strobes
//   PBusAddr, PBusDataIn  : bus word address and write data
//   RdData, Ack           : core read data and completion
//   ErrClr                : synchronous clear of BusErr
//   RD, WR                : one-cycle commands to the core
//   Addr, WrData          : latched address and write data
//   PBusDataOut, DataOE   : registered read data and its output-buffer enable
//   PBusReadyN            : active-low bus ready
//   BusErr                : sticky error flag (conflict or timeout)
module pbus_cycle_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PBusRDN,
  input  logic        PBusWRN,
  input  logic [16:2] PBusAddr,
  input  logic [31:0] PBusDataIn,
  input  logic [31:0] RdData,
  input  logic        Ack,
  input  logic        ErrClr,
  output logic        RD,
  output logic        WR,
  output logic [16:2] Addr,
  output logic [31:0] WrData,
  output logic [31:0] PBusDataOut,
  output logic        DataOE,
  output logic        PBusReadyN,
  output logic        BusErr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pbus_cycle_ctrl: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("pbus_cycle_ctrl: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAITACK,
    READY,
    DRAIN
  } state_t;

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic                   rd_s;
  logic                   wr_s;
  logic                   strobe_s;
  logic                   timeout_hit;

  state_t                 state;
  logic                   op_rd;
  logic [CNT_W-1:0]       cnt;

  // Strobe synchronisers: inverted on entry so "1" means strobe active and
  // the reset value is "strobe inactive".
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_sync <= '0;
      wr_sync <= '0;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], ~PBusRDN};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], ~PBusWRN};
    end
  end

  assign rd_s        = rd_sync[SYNC_STAGES-1];
  assign wr_s        = wr_sync[SYNC_STAGES-1];
  // Only the strobe that opened the transaction governs its completion.
  assign strobe_s    = op_rd ? rd_s : wr_s;
  assign timeout_hit = (cnt == CNT_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      op_rd       <= 1'b0;
      cnt         <= '0;
      RD          <= 1'b0;
      WR          <= 1'b0;
      Addr        <= '0;
      WrData      <= '0;
      PBusDataOut <= '0;
      DataOE      <= 1'b0;
      PBusReadyN  <= 1'b1;
      BusErr      <= 1'b0;
    end else begin
      RD <= 1'b0;
      WR <= 1'b0;
      // Clear first; any set below in the same cycle overrides it.
      if (ErrClr) begin
        BusErr <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rd_s && wr_s) begin
            BusErr <= 1'b1;
            state  <= DRAIN;
          end else if (rd_s) begin
            Addr  <= PBusAddr;
            op_rd <= 1'b1;
            RD    <= 1'b1;
            state <= CMD;
          end else if (wr_s) begin
            Addr   <= PBusAddr;
            WrData <= PBusDataIn;
            op_rd  <= 1'b0;
            WR     <= 1'b1;
            state  <= CMD;
          end
        end

        CMD: begin
          cnt   <= '0;
          state <= WAITACK;
        end

        WAITACK: begin
          if (Ack || timeout_hit) begin
            if (Ack) begin
              if (op_rd) begin
                PBusDataOut <= RdData;
              end
            end else begin
              BusErr <= 1'b1;
              if (op_rd) begin
                PBusDataOut <= 32'hFFFF_FFFF;
              end
            end
            // A strobe already released means nobody is waiting for ready.
            if (strobe_s) begin
              PBusReadyN <= 1'b0;
              DataOE     <= op_rd;
              state      <= READY;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        READY: begin
          if (!strobe_s) begin
            PBusReadyN <= 1'b1;
            DataOE     <= 1'b0;
            state      <= IDLE;
          end
        end

        DRAIN: begin
          if (!rd_s && !wr_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbus_cycle_ctrl.sv
// Directed bench for pbus_cycle_ctrl. Two instances share all inputs: one with
// default parameters and one with TIMEOUT=4 for the timeout scenario.
module tb_pbus_cycle_ctrl;

  logic        Clk;
  logic        Reset;
  logic        rdn;
  logic        wrn;
  logic [16:2] addr;
  logic [31:0] din;
  logic [31:0] rd_data;
  logic        ack;
  logic        err_clr;

  logic        rd_o, wr_o, oe_o, rdyn_o, err_o;
  logic [16:2] addr_o;
  logic [31:0] wdat_o, dout_o;

  logic        rd_t, wr_t, oe_t, rdyn_t, err_t;
  logic [16:2] addr_t;
  logic [31:0] wdat_t, dout_t;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int rdy_lo    = 0;
  int rd0, wr0, lo0;

  pbus_cycle_ctrl u_dut (
    .Clk(Clk), .Reset(Reset), .PBusRDN(rdn), .PBusWRN(wrn),
    .PBusAddr(addr), .PBusDataIn(din), .RdData(rd_data), .Ack(ack),
    .ErrClr(err_clr), .RD(rd_o), .WR(wr_o), .Addr(addr_o), .WrData(wdat_o),
    .PBusDataOut(dout_o), .DataOE(oe_o), .PBusReadyN(rdyn_o), .BusErr(err_o)
  );

  pbus_cycle_ctrl #(.SYNC_STAGES(2), .TIMEOUT(4)) u_dut_to (
    .Clk(Clk), .Reset(Reset), .PBusRDN(rdn), .PBusWRN(wrn),
    .PBusAddr(addr), .PBusDataIn(din), .RdData(rd_data), .Ack(ack),
    .ErrClr(err_clr), .RD(rd_t), .WR(wr_t), .Addr(addr_t), .WrData(wdat_t),
    .PBusDataOut(dout_t), .DataOE(oe_t), .PBusReadyN(rdyn_t), .BusErr(err_t)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Activity monitor on the default instance, sampled away from the edge.
  always @(negedge Clk) begin
    if (rd_o)    rd_pulses++;
    if (wr_o)    wr_pulses++;
    if (!rdyn_o) rdy_lo++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    Reset = 1'b1; rdn = 1'b1; wrn = 1'b1; addr = '0; din = '0;
    rd_data = '0; ack = 1'b0; err_clr = 1'b0;
    tick(2);
    Reset = 1'b0;
    tick();

    // Reset state
    check("rst_rd",    32'(rd_o),   32'd0);
    check("rst_wr",    32'(wr_o),   32'd0);
    check("rst_addr",  32'(addr_o), 32'd0);
    check("rst_wdat",  wdat_o,      32'd0);
    check("rst_dout",  dout_o,      32'd0);
    check("rst_oe",    32'(oe_o),   32'd0);
    check("rst_rdyn",  32'(rdyn_o), 32'd1);
    check("rst_err",   32'(err_o),  32'd0);

    // Zero-wait read
    rd_data = 32'h1234_5678; addr = 15'h0042; ack = 1'b1; rdn = 1'b0;
    rd0 = rd_pulses;
    tick(2);                                   // edges 0,1
    check("zw_rd_early", 32'(rd_o), 32'd0);
    tick();                                    // edge 2
    check("zw_rd_pulse", 32'(rd_o),   32'd1);
    check("zw_addr",     32'(addr_o), 32'h42);
    tick();                                    // edge 3
    check("zw_rd_end",   32'(rd_o),   32'd0);
    check("zw_rdyn_e3",  32'(rdyn_o), 32'd1);
    tick();                                    // edge 4
    check("zw_rdyn_e4",  32'(rdyn_o), 32'd0);
    check("zw_oe",       32'(oe_o),   32'd1);
    check("zw_dout",     dout_o,      32'h1234_5678);
    check("zw_rd_count", 32'(rd_pulses - rd0), 32'd1);
    rdn = 1'b1; ack = 1'b0;
    tick(2);
    check("zw_rel_hold", 32'(rdyn_o), 32'd0);
    tick();
    check("zw_rel_rdyn", 32'(rdyn_o), 32'd1);
    check("zw_rel_oe",   32'(oe_o),   32'd0);
    tick();

    // Waited write
    addr = 15'h0100; din = 32'hCAFE_0001; wrn = 1'b0;
    wr0 = wr_pulses;
    tick(3);                                   // edge 2
    check("ww_wr_pulse", 32'(wr_o),   32'd1);
    check("ww_wdat",     wdat_o,      32'hCAFE_0001);
    check("ww_addr",     32'(addr_o), 32'h100);
    tick();
    check("ww_wr_end",   32'(wr_o),   32'd0);
    tick(4);
    check("ww_rdyn_wait", 32'(rdyn_o), 32'd1);
    ack = 1'b1;
    tick();
    check("ww_rdyn_ack", 32'(rdyn_o), 32'd0);
    check("ww_oe",       32'(oe_o),   32'd0);
    check("ww_dout_keep", dout_o,     32'h1234_5678);
    check("ww_wr_count", 32'(wr_pulses - wr0), 32'd1);
    ack = 1'b0; wrn = 1'b1;
    tick(3);
    check("ww_rel_rdyn", 32'(rdyn_o), 32'd1);
    tick();

    // Strobe conflict
    rd0 = rd_pulses; wr0 = wr_pulses; lo0 = rdy_lo;
    rdn = 1'b0; wrn = 1'b0;
    tick(3);
    check("cf_err", 32'(err_o), 32'd1);
    check("cf_rd",  32'(rd_o),  32'd0);
    check("cf_wr",  32'(wr_o),  32'd0);
    tick(3);
    check("cf_rdyn", 32'(rdyn_o), 32'd1);
    rdn = 1'b1; wrn = 1'b1;
    tick(3);
    check("cf_rd_count", 32'(rd_pulses - rd0), 32'd0);
    check("cf_wr_count", 32'(wr_pulses - wr0), 32'd0);
    check("cf_rdy_count", 32'(rdy_lo - lo0),   32'd0);
    err_clr = 1'b1;
    tick();
    check("cf_errclr",    32'(err_o), 32'd0);
    check("cf_errclr_to", 32'(err_t), 32'd0);
    err_clr = 1'b0;
    tick();

    // Early release with late Ack
    rd_data = 32'hA5A5_0003; addr = 15'h0007; ack = 1'b0;
    rd0 = rd_pulses; lo0 = rdy_lo;
    rdn = 1'b0;
    tick(3);                                   // edge 2
    check("er_rd_pulse", 32'(rd_o), 32'd1);
    rdn = 1'b1;
    tick(10);                                  // edges 3..12
    ack = 1'b1;
    tick();                                    // edge 13: Ack -> DRAIN
    ack = 1'b0;
    tick();
    check("er_rd_count",  32'(rd_pulses - rd0), 32'd1);
    check("er_rdy_count", 32'(rdy_lo - lo0),    32'd0);
    check("er_dout",      dout_o,               32'hA5A5_0003);
    check("er_rdyn",      32'(rdyn_o),          32'd1);
    check("er_to_dout",   dout_t,               32'hFFFF_FFFF);

    // Following read served normally
    rd_data = 32'h0BAD_F00D; addr = 15'h0011; ack = 1'b1; rd0 = rd_pulses;
    rdn = 1'b0;
    tick(5);                                   // edge 4
    check("fr_rdyn",     32'(rdyn_o), 32'd0);
    check("fr_oe",       32'(oe_o),   32'd1);
    check("fr_dout",     dout_o,      32'h0BAD_F00D);
    check("fr_addr",     32'(addr_o), 32'h11);
    check("fr_rd_count", 32'(rd_pulses - rd0), 32'd1);
    rdn = 1'b1; ack = 1'b0;
    tick(3);
    check("fr_rel_rdyn", 32'(rdyn_o), 32'd1);
    tick();

    // Timeout (TIMEOUT=4 instance); default instance keeps waiting
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_pre", 32'(err_t), 32'd0);
    tick();
    rd_data = 32'h55AA_55AA; addr = 15'h0020; ack = 1'b0;
    rdn = 1'b0;
    tick(3);                                   // edge 2
    check("to_rd_pulse", 32'(rd_t), 32'd1);
    tick(4);                                   // edge 6: last WAITACK cycle
    check("to_rdyn_wait", 32'(rdyn_t), 32'd1);
    check("to_err_wait",  32'(err_t),  32'd0);
    err_clr = 1'b1;
    tick();                                    // edge 7: timeout with ErrClr high
    check("to_err_set_wins", 32'(err_t),  32'd1);
    check("to_dout",         dout_t,      32'hFFFF_FFFF);
    check("to_rdyn",         32'(rdyn_t), 32'd0);
    check("to_oe",           32'(oe_t),   32'd1);
    check("to_main_waiting", 32'(rdyn_o), 32'd1);
    tick();
    check("to_errclr",   32'(err_t),  32'd0);
    check("to_rdyn_hold", 32'(rdyn_t), 32'd0);
    err_clr = 1'b0;

    // Reset in the middle of the default instance's WAITACK
    #2;
    Reset = 1'b1;
    #1;
    check("mr_rd",   32'(rd_o),   32'd0);
    check("mr_wr",   32'(wr_o),   32'd0);
    check("mr_addr", 32'(addr_o), 32'd0);
    check("mr_wdat", wdat_o,      32'd0);
    check("mr_dout", dout_o,      32'd0);
    check("mr_oe",   32'(oe_o),   32'd0);
    check("mr_rdyn", 32'(rdyn_o), 32'd1);
    check("mr_err",  32'(err_o),  32'd0);
    check("mr_to_rdyn", 32'(rdyn_t), 32'd1);
    rdn = 1'b1;
    rd0 = rd_pulses;
    tick(2);
    Reset = 1'b0;
    tick(6);
    check("mr_no_reissue", 32'(rd_pulses - rd0), 32'd0);
    check("mr_post_rdyn",  32'(rdyn_o), 32'd1);
    check("mr_post_addr",  32'(addr_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
